// File: rtl/patch_cache_sequencer.sv
// Patching-cache sequencer: writes an M-element block into the cache one element per cycle and replays it as indexed read sweeps.
// Optional build macro PATCH_SEQ_AUTOREAD_EN chains one read sweep directly after every block load.
module patch_cache_sequencer #(
  parameter int N      = 16,
  parameter int M      = 4,
  parameter int ADDR_W = 21,
  localparam int IW    = $clog2(M)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  input  logic [N-1:0]      blk_data [M],
  output logic              blk_ready,
  input  logic              start_read,
  input  logic              cache_error,
  output logic              request,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic [IW-1:0]     index,
  output logic              store_enable,
  output logic [N-1:0]      activation_in,
  output logic              loaded,
  output logic              read_busy,
  output logic [15:0]       blk_count,
  output logic              error_flag
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_READ} state_t;

  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  blk_buf [M];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      blk_count  <= '0;
      error_flag <= 1'b0;
      loaded     <= 1'b0;
      for (int i = 0; i < M; i++) blk_buf[i] <= '0;
    end else if (request && cache_error) begin
      // A cache error aborts any access in flight, including the counting cycle.
      error_flag <= 1'b1;
      state      <= S_IDLE;
      idx        <= '0;
      loaded     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid) begin
            blk_buf <= blk_data;
            idx     <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx == IDX_LAST) begin
            idx       <= '0;
            blk_count <= blk_count + 16'd1;
            loaded    <= 1'b1;
`ifdef PATCH_SEQ_AUTOREAD_EN
            state     <= S_READ;
`else
            state     <= S_LOADED;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOADED: begin
          // start_read has priority; blk_ready is held low so no block is lost.
          if (start_read) begin
            idx   <= '0;
            state <= S_READ;
          end else if (blk_valid) begin
            blk_buf <= blk_data;
            idx     <= '0;
            loaded  <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_READ: begin
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= S_LOADED;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign request       = (state == S_LOAD) || (state == S_READ);
  assign read_write    = (state == S_READ);
  assign store_enable  = (state == S_LOAD);
  assign read_busy     = (state == S_READ);
  assign index         = idx;
  assign address       = ADDR_W'(idx);
  assign activation_in = (state == S_LOAD) ? blk_buf[idx] : '0;
  assign blk_ready     = (state == S_IDLE) || ((state == S_LOADED) && !start_read);

endmodule

// File: tb/tb_patch_cache_sequencer.sv
// Bench for patch_cache_sequencer: directed steps with random block contents checked against an expected-transaction model.
module tb_patch_cache_sequencer;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          blk_valid = 1'b0;
  logic [N-1:0]  blk_data [M];
  logic          blk_ready;
  logic          start_read = 1'b0;
  logic          cache_error = 1'b0;
  logic          request, read_write, store_enable, loaded, read_busy, error_flag;
  logic [AW-1:0] address;
  logic [1:0]    index;
  logic [N-1:0]  activation_in;
  logic [15:0]   blk_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic exp_err = 1'b0;

  patch_cache_sequencer #(.N(N), .M(M), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(blk_ready), .start_read(start_read), .cache_error(cache_error),
    .request(request), .read_write(read_write), .address(address), .index(index),
    .store_enable(store_enable), .activation_in(activation_in), .loaded(loaded),
    .read_busy(read_busy), .blk_count(blk_count), .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".request"}, request, 0);
    chk({tag, ".store_enable"}, store_enable, 0);
    chk({tag, ".read_write"}, read_write, 0);
    chk({tag, ".activation_in"}, activation_in, 0);
    chk({tag, ".address"}, address, 0);
    chk({tag, ".index"}, index, 0);
    chk({tag, ".loaded"}, loaded, 0);
    chk({tag, ".read_busy"}, read_busy, 0);
    chk({tag, ".blk_count"}, blk_count, 0);
    chk({tag, ".error_flag"}, error_flag, 0);
  endtask

  task automatic rand_block(output logic [N-1:0] d [M]);
    for (int i = 0; i < M; i++) d[i] = N'($urandom);
  endtask

  // Expected sweep: M read accesses on indices 0..M-1, then an idle LOADED cycle.
  task automatic check_reads();
    for (int i = 0; i < M; i++) begin
      chk("rd.request", request, 1);
      chk("rd.read_write", read_write, 1);
      chk("rd.store_enable", store_enable, 0);
      chk("rd.read_busy", read_busy, 1);
      chk("rd.index", index, i);
      chk("rd.address", address, i);
      chk("rd.blk_ready", blk_ready, 0);
      @(negedge clk);
    end
    chk("rd_done.loaded", loaded, 1);
    chk("rd_done.read_busy", read_busy, 0);
    chk("rd_done.request", request, 0);
    chk("rd_done.blk_count", blk_count, exp_cnt);
    chk("rd_done.error_flag", error_flag, exp_err);
  endtask

  // Expected load: element i written at index i on the i-th cycle after the handshake.
  task automatic check_writes(input logic [N-1:0] d [M]);
    for (int i = 0; i < M; i++) begin
      chk("wr.request", request, 1);
      chk("wr.store_enable", store_enable, 1);
      chk("wr.read_write", read_write, 0);
      chk("wr.index", index, i);
      chk("wr.address", address, i);
      chk("wr.activation_in", activation_in, d[i]);
      chk("wr.loaded", loaded, 0);
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("wr_done.loaded", loaded, 1);
    chk("wr_done.blk_count", blk_count, exp_cnt);
`ifdef PATCH_SEQ_AUTOREAD_EN
    check_reads();
`else
    chk("wr_done.request", request, 0);
    chk("wr_done.activation_in", activation_in, 0);
    chk("wr_done.blk_ready", blk_ready, 1);
`endif
  endtask

  task automatic present(input logic [N-1:0] d [M]);
    blk_data = d;
    blk_valid = 1'b1;
    #1 chk("hs.blk_ready", blk_ready, 1);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic send_block(input logic [N-1:0] d [M]);
    present(d);
    check_writes(d);
  endtask

  task automatic sweep();
    start_read = 1'b1;
    #1 chk("sweep.blk_ready", blk_ready, 0);
    @(negedge clk);
    start_read = 1'b0;
    check_reads();
  endtask

  initial begin
    logic [N-1:0] d [M];
    logic [N-1:0] d2 [M];
    for (int i = 0; i < M; i++) blk_data[i] = '0;

    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;
    #1 chk("post_reset.blk_ready", blk_ready, 1);
    @(negedge clk);

    d[0] = 16'h0011; d[1] = 16'h0022; d[2] = 16'h0033; d[3] = 16'h0044;
    send_block(d);
    sweep();

    for (int k = 0; k < 3; k++) begin
      rand_block(d);
      send_block(d);
      if (k != 1) sweep();
    end

    // start_read and blk_valid together: sweep wins, block waits for the next LOADED cycle.
    rand_block(d2);
    blk_data = d2;
    blk_valid = 1'b1;
    start_read = 1'b1;
    #1 chk("collide.blk_ready", blk_ready, 0);
    @(negedge clk);
    start_read = 1'b0;
    check_reads();
    chk("collide.accept_ready", blk_ready, 1);
    @(negedge clk);
    blk_valid = 1'b0;
    check_writes(d2);

    // Cache error on index 2 of a load.
    rand_block(d);
    present(d);
    repeat (2) @(negedge clk);
    chk("err2.index", index, 2);
    cache_error = 1'b1;
    @(negedge clk);
    cache_error = 1'b0;
    exp_err = 1'b1;
    chk("err2.error_flag", error_flag, 1);
    chk("err2.loaded", loaded, 0);
    chk("err2.request", request, 0);
    chk("err2.index", index, 0);
    chk("err2.blk_count", blk_count, exp_cnt);
    chk("err2.blk_ready", blk_ready, 1);

    // Cache error on the final load cycle must not count the block.
    rand_block(d);
    present(d);
    repeat (3) @(negedge clk);
    chk("err3.index", index, 3);
    cache_error = 1'b1;
    @(negedge clk);
    cache_error = 1'b0;
    chk("err3.blk_count", blk_count, exp_cnt);
    chk("err3.loaded", loaded, 0);
    chk("err3.error_flag", error_flag, 1);

    rand_block(d);
    send_block(d);
    chk("err_sticky.error_flag", error_flag, 1);

    // Asynchronous reset in the middle of a sweep.
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    @(negedge clk);
    chk("midread.index", index, 1);
    chk("midread.read_busy", read_busy, 1);
    reset = 1'b1;
    #1 chk_reset_values("midread_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rand_block(d);
    send_block(d);
    chk("after_reset.error_flag", error_flag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/patch_cache_sequencer.md
# patch_cache_sequencer

Sequencer for the patching-cache datapath. Accepts blocks of M activations over a valid/ready handshake, writes them into the patching cache one element per cycle, and replays the stored block as an indexed read sweep on demand. It drives the cache port signals `request`, `read_write`, `address`, `index`, `store_enable` and `activation_in`, and sits between the activation source and `top_patching_final`.

## Interface
- `N`, 16, activation width in bits
- `M`, 4, activations per block; power of two, ≥ 2
- `ADDR_W`, 21, cache address width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `blk_valid`  in  1  a block is present on `blk_data`
- `blk_data`  in  N × [M]  unpacked block of activations
- `blk_ready`  out  1  sequencer can accept a block
- `start_read`  in  1  request one read sweep of the stored block
- `cache_error`  in  1  error reported by the cache on the current access
- `request`  out  1  cache access strobe
- `read_write`  out  1  0 = write, 1 = read
- `address`  out  ADDR_W  zero-extended element index
- `index`  out  log2(M)  element index
- `store_enable`  out  1  cache write enable
- `activation_in`  out  N  write data
- `loaded`  out  1  cache holds a complete block
- `read_busy`  out  1  read sweep in progress
- `blk_count`  out  16  blocks fully written; wraps from 0xFFFF to 0
- `error_flag`  out  1  sticky cache-error indicator

## Operation
- States: IDLE, LOAD, LOADED, READ.
- IDLE: `blk_ready` = 1. A handshake (`blk_valid` & `blk_ready`) captures `blk_data` into an internal M×N buffer, clears `idx`, and moves to LOAD.
- LOAD: `request` = 1, `store_enable` = 1, `read_write` = 0, `activation_in` = buf[idx]. `idx` increments each cycle. At `idx` = M−1: `idx` ← 0, `blk_count`++, next state is LOADED.
- LOADED: `loaded` = 1 and `blk_ready` = 1.
  - `start_read` moves to READ with `idx` = 0.
  - Otherwise a handshake captures a new block and moves to LOAD; `loaded` clears.
  - If both occur in the same cycle, `start_read` wins, `blk_ready` is forced to 0 that cycle, and the block is not accepted.
- READ: `request` = 1, `read_write` = 1, `store_enable` = 0, `read_busy` = 1. `idx` increments each cycle and wraps to 0 at M−1, returning to LOADED. `start_read` and `blk_valid` are ignored during READ.
- All states: `index` = `idx` and `address` = `idx` zero-extended to ADDR_W. In IDLE and LOADED, `request` = 0, `store_enable` = 0, `read_write` = 0 and `activation_in` = 0.
- `cache_error` sampled while `request` = 1:
  - sets `error_flag`, which stays set until reset;
  - aborts to IDLE with `idx` = 0 and `loaded` = 0;
  - leaves `blk_count` unchanged if the error hits the final LOAD cycle.
- Arithmetic: `idx` is log2(M) bits and wraps naturally. `blk_count` is a 16-bit modulo counter.

## Timing
- Moore machine: every cache-port output decodes from registered state and `idx`. `blk_ready` is the only output with a combinational path, to `start_read` in LOADED.
- Handshake at cycle T: LOAD write cycles T+1 … T+M; `loaded` = 1 and `blk_count` updated from T+M+1.
- `start_read` sampled at cycle T in LOADED: READ cycles T+1 … T+M; back in LOADED at T+M+1.
- Back-to-back: a block can be accepted in the first LOADED cycle, giving M+1 cycles per block.
- Reset values: state IDLE, `idx` = 0, buffer = 0, `blk_count` = 0, `error_flag` = 0, `loaded` = 0, `read_busy` = 0, `request` = 0, `store_enable` = 0, `read_write` = 0, `activation_in` = 0, `address` = 0, `index` = 0, `blk_ready` = 1 once reset deasserts.
- Reset asserted mid-LOAD or mid-READ: immediate return to all reset values; the partial block is discarded and not counted.

## Configuration
- `PATCH_SEQ_AUTOREAD_EN` defined: LOAD completion goes directly to READ, skipping the idle LOADED cycle. `blk_count` and `loaded` still update at T+M+1. `start_read` still triggers extra sweeps from LOADED.
- Not defined: READ is entered only via `start_read`, as described above.

## Test plan
- Reset, then handshake a block {0x0011, 0x0022, 0x0033, 0x0044} (M = 4) → writes to `index` 0..3 with matching `activation_in` on T+1..T+4; `loaded` = 1 and `blk_count` = 1 at T+5.
- `start_read` in LOADED → `read_write` = 1, `request` = 1, `index` 0,1,2,3 over 4 cycles, `read_busy` high throughout; LOADED again after, with `blk_count` still 1.
- `start_read` and `blk_valid` in the same LOADED cycle → `blk_ready` = 0, READ is entered, the block is not consumed; it is accepted in the first LOADED cycle after the sweep.
- `cache_error` pulsed during LOAD `index` 2 → `error_flag` = 1 the next cycle, state IDLE, `loaded` = 0, `blk_count` unchanged; `error_flag` persists across later blocks until reset.
- `reset` asserted mid-READ at `index` 1 → all outputs return to reset values asynchronously; a new block then loads normally with `blk_count` = 1.
- `PATCH_SEQ_AUTOREAD_EN` build: one handshake → 4 write cycles immediately followed by 4 read cycles with no idle cycle between; `blk_count` = 1 at T+5.
